// File: rtl/cordic_pkg.sv
// Shared types and elaboration-time constants for the pipelined CORDIC engine.
// Angles are binary: a full circle is 2^zw counts.
package cordic_pkg;

    typedef enum logic {
        CORDIC_ROT = 1'b0,
        CORDIC_VEC = 1'b1
    } cordic_mode_e;

    localparam real CORDIC_PI = 3.14159265358979323846;

    function automatic int quarter_turn(input int zw);
        return 1 << (zw - 2);
    endfunction

    // atan(2^-i) as a binary angle, rounded. A Taylor series keeps this free of
    // math system functions; for i >= 1 the argument is <= 0.5, so 24 terms suffice.
    function automatic int atan_lut(input int i, input int zw);
        real t;
        real t2;
        real term;
        real sum;
        real frac;
        real scale;
        t = 1.0;
        for (int k = 0; k < i; k++) t = t / 2.0;
        if (i == 0) begin
            frac = 0.125;
        end else begin
            t2   = t * t;
            term = t;
            sum  = 0.0;
            for (int k = 0; k < 24; k++) begin
                if (k % 2 == 0) sum = sum + term / real'(2 * k + 1);
                else            sum = sum - term / real'(2 * k + 1);
                term = term * t2;
            end
            frac = sum / (2.0 * CORDIC_PI);
        end
        scale = 1.0;
        for (int k = 0; k < zw; k++) scale = scale * 2.0;
        return $rtoi(frac * scale + 0.5);
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation by atan(2^-SHIFT); loads only when en is high
// so the whole pipeline can stall together.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int             W2    = 18,
    parameter int             ZW    = 16,
    parameter int             SHIFT = 0,
    parameter logic [ZW-1:0]  ANGLE = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in_valid,
    input  cordic_mode_e         in_mode,
    input  logic signed [W2-1:0] x_in,
    input  logic signed [W2-1:0] y_in,
    input  logic signed [ZW-1:0] z_in,
    output logic                 out_valid,
    output cordic_mode_e         out_mode,
    output logic signed [W2-1:0] x_out,
    output logic signed [W2-1:0] y_out,
    output logic signed [ZW-1:0] z_out
);

    logic                 valid_d, valid_q;
    cordic_mode_e         mode_d, mode_q;
    logic signed [W2-1:0] x_d, x_q;
    logic signed [W2-1:0] y_d, y_q;
    logic signed [ZW-1:0] z_d, z_q;
    logic signed [W2-1:0] x_sh, y_sh;
    logic                 dir_pos;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        valid_d = in_valid;
        mode_d  = in_mode;
        x_sh    = x_in >>> SHIFT;
        y_sh    = y_in >>> SHIFT;
        dir_pos = (in_mode == CORDIC_ROT) ? !z_in[ZW-1] : y_in[W2-1];
        x_d     = x_in + y_sh;
        y_d     = y_in - x_sh;
        z_d     = z_in + $signed(ANGLE);
        if (dir_pos) begin
            x_d = x_in - y_sh;
            y_d = y_in + x_sh;
            z_d = z_in - $signed(ANGLE);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so stages read each
    // other's pre-edge values regardless of evaluation order.
    // NOTE: data registers are reset too, so outputs read as zero straight after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            mode_q  <= CORDIC_ROT;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else if (en) begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
        end
    end

    assign out_valid = valid_q;
    assign out_mode  = mode_q;
    assign x_out     = x_q;
    assign y_out     = y_q;
    assign z_out     = z_q;

endmodule

// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC (rotation / vectoring) with quadrant pre-rotation and a
// valid/ready stream interface; the pipeline stalls globally under backpressure.
module cordic_pipe
    import cordic_pkg::*;
#(
    parameter int W      = 16,
    parameter int ZW     = 16,
    parameter int STAGES = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic signed [W-1:0]  x_in,
    input  logic signed [W-1:0]  y_in,
    input  logic signed [ZW-1:0] z_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_mode,
    output logic signed [W+1:0]  x_out,
    output logic signed [W+1:0]  y_out,
    output logic signed [ZW-1:0] z_out
);

    localparam int                   W2  = W + 2;
    localparam logic signed [ZW-1:0] QTR = ZW'(quarter_turn(ZW));

    logic advance;

    logic                 pre_valid_d, pre_valid_q;
    cordic_mode_e         pre_mode_d, pre_mode_q;
    logic signed [W2-1:0] pre_x_d, pre_x_q;
    logic signed [W2-1:0] pre_y_d, pre_y_q;
    logic signed [ZW-1:0] pre_z_d, pre_z_q;
    logic signed [W2-1:0] x_ext, y_ext;

    logic                 s_valid [STAGES+1];
    cordic_mode_e         s_mode  [STAGES+1];
    logic signed [W2-1:0] s_x     [STAGES+1];
    logic signed [W2-1:0] s_y     [STAGES+1];
    logic signed [ZW-1:0] s_z     [STAGES+1];

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Pre-rotation by +/-90 deg brings every sample into the micro-rotations' range.
    always_comb begin
        x_ext       = {{2{x_in[W-1]}}, x_in};
        y_ext       = {{2{y_in[W-1]}}, y_in};
        pre_valid_d = in_valid;
        pre_mode_d  = cordic_mode_e'(in_mode);
        pre_x_d     = x_ext;
        pre_y_d     = y_ext;
        pre_z_d     = z_in;
        if (pre_mode_d == CORDIC_ROT) begin
            case (z_in[ZW-1 -: 2])
                2'b01: begin
                    pre_x_d = -y_ext;
                    pre_y_d = x_ext;
                    pre_z_d = z_in - QTR;
                end
                2'b10: begin
                    pre_x_d = y_ext;
                    pre_y_d = -x_ext;
                    pre_z_d = z_in + QTR;
                end
                default: ;
            endcase
        end else if (x_in[W-1]) begin
            if (!y_in[W-1]) begin
                pre_x_d = y_ext;
                pre_y_d = -x_ext;
                pre_z_d = z_in + QTR;
            end else begin
                pre_x_d = -y_ext;
                pre_y_d = x_ext;
                pre_z_d = z_in - QTR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_valid_q <= 1'b0;
            pre_mode_q  <= CORDIC_ROT;
            pre_x_q     <= '0;
            pre_y_q     <= '0;
            pre_z_q     <= '0;
        end else if (advance) begin
            pre_valid_q <= pre_valid_d;
            pre_mode_q  <= pre_mode_d;
            pre_x_q     <= pre_x_d;
            pre_y_q     <= pre_y_d;
            pre_z_q     <= pre_z_d;
        end
    end

    assign s_valid[0] = pre_valid_q;
    assign s_mode[0]  = pre_mode_q;
    assign s_x[0]     = pre_x_q;
    assign s_y[0]     = pre_y_q;
    assign s_z[0]     = pre_z_q;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        cordic_stage #(
            .W2    (W2),
            .ZW    (ZW),
            .SHIFT (i),
            .ANGLE (ZW'(atan_lut(i, ZW)))
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (advance),
            .in_valid  (s_valid[i]),
            .in_mode   (s_mode[i]),
            .x_in      (s_x[i]),
            .y_in      (s_y[i]),
            .z_in      (s_z[i]),
            .out_valid (s_valid[i+1]),
            .out_mode  (s_mode[i+1]),
            .x_out     (s_x[i+1]),
            .y_out     (s_y[i+1]),
            .z_out     (s_z[i+1])
        );
    end

    assign out_valid = s_valid[STAGES];
    assign out_mode  = s_mode[STAGES];
    assign x_out     = s_x[STAGES];
    assign y_out     = s_y[STAGES];
    assign z_out     = s_z[STAGES];

endmodule

// File: tb/tb_cordic_pipe.sv
// Self-checking bench for cordic_pipe: spec vectors with tolerance, a bit-accurate
// arithmetic reference model, backpressure, random traffic and mid-stream reset.
module tb_cordic_pipe;

    localparam int W      = 16;
    localparam int ZW     = 16;
    localparam int STAGES = 14;
    localparam int LAT    = STAGES + 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_mode;
    logic signed [W-1:0]  x_in;
    logic signed [W-1:0]  y_in;
    logic signed [ZW-1:0] z_in;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_mode;
    logic signed [W+1:0]  x_out;
    logic signed [W+1:0]  y_out;
    logic signed [ZW-1:0] z_out;

    cordic_pipe #(.W(W), .ZW(ZW), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit      mode;
        longint  x;
        longint  y;
        longint  z;
    } res_t;

    typedef struct {
        bit  mode;
        int  x, y, z;
        int  xe, ye, ze;
        bit  chk_z;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   a_tab [STAGES];
    res_t sb [$];

    function automatic longint wrapn(input longint v, input int n);
        longint m;
        m = longint'(1) << n;
        v = v % m;
        if (v < 0) v += m;
        if (v >= m / 2) v -= m;
        return v;
    endfunction

    // Geometric reference: quadrant fold by whole quarter turns, then the
    // shift-and-add iterations on plain integers with the stated wraps.
    function automatic res_t model(input bit m, input int xi, input int yi, input int zi);
        res_t   r;
        longint x, y, z, t, dx, dy;
        longint q;
        bit     pos;
        q = longint'(1) << (ZW - 2);
        x = wrapn(xi, W);
        y = wrapn(yi, W);
        z = wrapn(zi, ZW);
        if (!m) begin
            if (z >= q) begin t = x; x = -y; y = t; z -= q; end
            else if (z < -q) begin t = x; x = y; y = -t; z += q; end
        end else if (x < 0) begin
            if (y >= 0) begin t = x; x = y; y = -t; z += q; end
            else begin t = x; x = -y; y = t; z -= q; end
        end
        z = wrapn(z, ZW);
        for (int i = 0; i < STAGES; i++) begin
            pos = m ? (y < 0) : (z >= 0);
            dx  = y >>> i;
            dy  = x >>> i;
            if (pos) begin x = x - dx; y = y + dy; z = z - a_tab[i]; end
            else     begin x = x + dx; y = y - dy; z = z + a_tab[i]; end
            x = wrapn(x, W + 2);
            y = wrapn(y, W + 2);
            z = wrapn(z, ZW);
        end
        r.mode = m;
        r.x = x;
        r.y = y;
        r.z = z;
        return r;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input longint act, input longint exp,
                             input int tol, input bit angle);
        longint diff;
        n_vec++;
        diff = act - exp;
        if (angle) diff = wrapn(diff, ZW);
        if (diff > tol || diff < -tol) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    // One cycle of streaming traffic with scoreboard bookkeeping; both handshakes
    // observed here complete at the following rising edge.
    task automatic step(input bit iv, input bit ordy, output bit accepted);
        res_t e;
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        in_mode   = 1'($urandom);
        x_in      = 16'($urandom);
        y_in      = 16'($urandom);
        z_in      = 16'($urandom);
        #1;
        accepted = 1'b0;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = sb.pop_front();
                check("stream_mode", longint'(out_mode), longint'(e.mode));
                check("stream_x", x_out, e.x);
                check("stream_y", y_out, e.y);
                check("stream_z", z_out, e.z);
            end
        end
        if (in_valid && in_ready) begin
            sb.push_back(model(in_mode, int'(x_in), int'(y_in), int'(z_in)));
            accepted = 1'b1;
        end
    endtask

    task automatic drain();
        bit a;
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            step(1'b0, 1'b1, a);
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    // Single isolated sample on an idle pipeline; lat counts rising edges from
    // (and including) the accepting edge until out_valid is seen.
    task automatic apply_one(input bit m, input int x, input int y, input int z,
                             output int lat, output res_t got);
        bit seen;
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_mode   = m;
        x_in      = 16'(x);
        y_in      = 16'(y);
        z_in      = 16'(z);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) seen = 1'b1;
        end
        if (!seen) check("result_timeout", 0, 1);
        got.mode = out_mode;
        got.x    = x_out;
        got.y    = y_out;
        got.z    = z_out;
    endtask

    initial begin
        vec_t   tbl [5];
        res_t   got, exp;
        int     lat;
        bit     a;
        int     acc, cyc;
        longint sx, sy, sz;

        for (int i = 0; i < STAGES; i++)
            a_tab[i] = int'($floor($atan(1.0 / (2.0 ** i)) * 65536.0 / (2.0 * 3.141592653589793) + 0.5));

        tbl[0] = '{mode: 1'b0, x: 19898,  y: 0,     z: 'h2000, xe: 23170,  ye: 23170, ze: 0,      chk_z: 1'b1};
        tbl[1] = '{mode: 1'b1, x: 10000,  y: 10000, z: 0,      xe: 23290,  ye: 0,     ze: 'h2000, chk_z: 1'b1};
        tbl[2] = '{mode: 1'b0, x: 19898,  y: 0,     z: 'h8000, xe: -32767, ye: 0,     ze: 0,      chk_z: 1'b1};
        tbl[3] = '{mode: 1'b1, x: -10000, y: 0,     z: 0,      xe: 16468,  ye: 0,     ze: 'h8000, chk_z: 1'b1};
        tbl[4] = '{mode: 1'b1, x: 0,      y: 0,     z: 0,      xe: 0,      ye: 0,     ze: 0,      chk_z: 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        x_in      = '0;
        y_in      = '0;
        z_in      = '0;
        out_ready = 1'b1;

        #12;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_x_out", x_out, 0);
        check("rst_y_out", y_out, 0);
        check("rst_z_out", z_out, 0);
        check("rst_out_mode", longint'(out_mode), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            apply_one(tbl[i].mode, tbl[i].x, tbl[i].y, tbl[i].z, lat, got);
            exp = model(tbl[i].mode, tbl[i].x, tbl[i].y, tbl[i].z);
            check($sformatf("vec%0d_latency", i), lat, LAT);
            check($sformatf("vec%0d_mode", i), longint'(got.mode), longint'(tbl[i].mode));
            check_tol($sformatf("vec%0d_x", i), got.x, tbl[i].xe, 4, 1'b0);
            check_tol($sformatf("vec%0d_y", i), got.y, tbl[i].ye, 4, 1'b0);
            if (tbl[i].chk_z) begin
                check_tol($sformatf("vec%0d_z", i), got.z, tbl[i].ze, 2, 1'b1);
                check($sformatf("vec%0d_z_exact", i), got.z, exp.z);
            end
            check($sformatf("vec%0d_x_exact", i), got.x, exp.x);
            check($sformatf("vec%0d_y_exact", i), got.y, exp.y);
        end

        // Most negative inputs must negate cleanly inside the guard bits.
        apply_one(1'b0, -32768, -32768, 'h8000, lat, got);
        exp = model(1'b0, -32768, -32768, 'h8000);
        check("minneg_rot_x", got.x, exp.x);
        check("minneg_rot_y", got.y, exp.y);
        check("minneg_rot_z", got.z, exp.z);
        apply_one(1'b1, -32768, 100, 0, lat, got);
        exp = model(1'b1, -32768, 100, 0);
        check("minneg_vec_x", got.x, exp.x);
        check("minneg_vec_z", got.z, exp.z);

        // Backpressure: continuous input, consumer stalls for 5 cycles.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, a);
        sx = 0; sy = 0; sz = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, a);
            check("bp_in_ready_low", longint'(in_ready), 0);
            check("bp_out_valid", longint'(out_valid), 1);
            if (k == 0) begin
                sx = x_out; sy = y_out; sz = z_out;
            end else begin
                check("bp_frozen_x", x_out, sx);
                check("bp_frozen_y", y_out, sy);
                check("bp_frozen_z", z_out, sz);
            end
        end
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, a);
        drain();

        // Random interleaved modes, bubbles and stalls.
        acc = 0;
        cyc = 0;
        while (acc < 1000 && cyc < 8000) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, a);
            if (a) acc++;
            cyc++;
        end
        check("rand_accepted", acc, 1000);
        drain();

        // Reset with the pipeline full.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, a);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_x_out", x_out, 0);
        check("midrst_y_out", y_out, 0);
        check("midrst_z_out", z_out, 0);
        check("midrst_out_mode", longint'(out_mode), 0);
        sb.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apply_one(1'b0, 12345, -6789, 'h5a5a, lat, got);
        exp = model(1'b0, 12345, -6789, 'h5a5a);
        check("postrst_latency", lat, LAT);
        check("postrst_x", got.x, exp.x);
        check("postrst_y", got.y, exp.y);
        check("postrst_z", got.z, exp.z);
        @(negedge clk);
        check("postrst_idle", longint'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
